// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array controller and its MAC PEs.
// Holds the controller state encoding, MAC pipeline depth and Q1.15 format constants.
package systolic_pkg;

  localparam int unsigned MAC_PIPE_LATENCY = 2;

  localparam int unsigned Q_WIDTH     = 16;
  localparam int unsigned Q_FRAC_BITS = 15;
  localparam logic [15:0] Q_MAX       = 16'h7FFF;
  localparam logic [15:0] Q_MIN       = 16'h8000;
  localparam logic [15:0] Q_HALF      = 16'h4000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_COMPUTE,
    ST_DRAIN,
    ST_DONE
  } ctrl_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/systolic_array_ctrl_skew_shift.sv
// Column skew delay line: tap c is the compute window delayed c cycles.
// Freezes with hold so the skew resumes exactly where it stalled.
module skew_shift #(
  parameter int unsigned TAPS = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            hold,
  input  logic            w,
  output logic [TAPS-1:0] tap
);

  if (TAPS > 1) begin : g_line
    logic [TAPS-2:0] sr_q;
    logic [TAPS-2:0] sr_d;

    always_comb begin
      sr_d = sr_q;
      if (!hold) begin
        sr_d = (TAPS-1)'({sr_q, w});
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        sr_q <= '0;
      end else begin
        sr_q <= sr_d;
      end
    end

    assign tap = {sr_q, w};
  end else begin : g_wire
    assign tap = w;
  end

endmodule

// File: rtl/systolic_array_ctrl.sv
// Job sequencer for a weight-stationary systolic array: clear, weight load,
// activation streaming and skew/pipeline drain, with a global freeze on hold.
module systolic_array_ctrl #(
  parameter int unsigned ARRAY_DIM        = 4,
  parameter int unsigned K_BITS           = 8,
  parameter int unsigned ADDR_BITS        = 8,
  parameter int unsigned MEM_LATENCY      = 1,
  parameter int unsigned MAC_PIPE_LATENCY = systolic_pkg::MAC_PIPE_LATENCY
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [K_BITS-1:0]    k_len,
  input  logic [ADDR_BITS-1:0] wgt_base,
  input  logic [ADDR_BITS-1:0] act_base,
  input  logic                 hold,
  output logic                 busy,
  output logic                 done,
  output logic                 wgt_rd_en,
  output logic [ADDR_BITS-1:0] wgt_rd_addr,
  output logic                 act_rd_en,
  output logic [ADDR_BITS-1:0] act_rd_addr,
  output logic                 pe_enable,
  output logic                 clear_acc,
  output logic                 load_weight,
  output logic [ARRAY_DIM-1:0] compute_en
);

  import systolic_pkg::*;

  localparam int unsigned LOAD_LEN  = ARRAY_DIM + MEM_LATENCY;
  localparam int unsigned DRAIN_LEN = MEM_LATENCY + ARRAY_DIM - 1 + MAC_PIPE_LATENCY;
  localparam int unsigned K_MAX     = (1 << K_BITS) - 1;
  localparam int unsigned CNT_MAX   = max_u(max_u(LOAD_LEN, K_MAX), DRAIN_LEN);
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

  ctrl_state_t          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [K_BITS-1:0]    k_len_q, k_len_d;
  logic [ADDR_BITS-1:0] wgt_base_q, wgt_base_d;
  logic [ADDR_BITS-1:0] act_base_q, act_base_d;
  logic [MEM_LATENCY-1:0] w_q, w_d;

  logic                 clear_acc_c;
  logic                 load_weight_c;
  logic                 done_c;
  logic                 wgt_rd_en_c;
  logic [ADDR_BITS-1:0] wgt_rd_addr_c;
  logic                 act_rd_en_c;
  logic [ADDR_BITS-1:0] act_rd_addr_c;

  // Next-state and strobe decode; hold freezes everything and silences strobes.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    k_len_d       = k_len_q;
    wgt_base_d    = wgt_base_q;
    act_base_d    = act_base_q;
    clear_acc_c   = 1'b0;
    load_weight_c = 1'b0;
    done_c        = 1'b0;
    wgt_rd_en_c   = 1'b0;
    wgt_rd_addr_c = '0;
    act_rd_en_c   = 1'b0;
    act_rd_addr_c = '0;

    if (!hold) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            k_len_d    = k_len;
            wgt_base_d = wgt_base;
            act_base_d = act_base;
            cnt_d      = '0;
            state_d    = ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          clear_acc_c = 1'b1;
          cnt_d       = '0;
          state_d     = ST_LOAD;
        end
        ST_LOAD: begin
          // Last weight row goes first so each row lands at its own PE row.
          if (cnt_q < CNT_W'(ARRAY_DIM)) begin
            wgt_rd_en_c   = 1'b1;
            wgt_rd_addr_c = wgt_base_q + ADDR_BITS'(ARRAY_DIM - 1) - ADDR_BITS'(cnt_q);
          end
          if (cnt_q == CNT_W'(LOAD_LEN - 1)) begin
            load_weight_c = 1'b1;
            cnt_d         = '0;
            state_d       = (k_len_q == '0) ? ST_DONE : ST_COMPUTE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_COMPUTE: begin
          act_rd_en_c   = 1'b1;
          act_rd_addr_c = act_base_q + ADDR_BITS'(cnt_q);
          if (cnt_q == CNT_W'(k_len_q) - CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          if (cnt_q == CNT_W'(DRAIN_LEN - 1)) begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          done_c  = 1'b1;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Compute window delayed by the SRAM read latency.
  always_comb begin
    w_d = w_q;
    if (!hold) begin
      w_d = MEM_LATENCY'({w_q, (state_q == ST_COMPUTE)});
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      k_len_q    <= '0;
      wgt_base_q <= '0;
      act_base_q <= '0;
      w_q        <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      k_len_q    <= k_len_d;
      wgt_base_q <= wgt_base_d;
      act_base_q <= act_base_d;
      w_q        <= w_d;
    end
  end

  skew_shift #(
    .TAPS(ARRAY_DIM)
  ) u_skew (
    .clk  (clk),
    .reset(reset),
    .hold (hold),
    .w    (w_q[MEM_LATENCY-1]),
    .tap  (compute_en)
  );

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_c;
  assign clear_acc   = clear_acc_c;
  assign load_weight = load_weight_c;
  assign wgt_rd_en   = wgt_rd_en_c;
  assign wgt_rd_addr = wgt_rd_addr_c;
  assign act_rd_en   = act_rd_en_c;
  assign act_rd_addr = act_rd_addr_c;
  assign pe_enable   = ~hold;

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed bench for systolic_array_ctrl: per-cycle strobe traces against a
// hand-derived job timeline, plus a 4x4 Q1.15 PE array and SRAM models.
module tb_systolic_array_ctrl;

  localparam int N = 4;
  localparam logic [26:0] IDLE_VEC    = 27'h4000000;
  localparam logic [26:0] ADDR_FIELDS = 27'h01FEFF0;

  logic       clk = 1'b0;
  logic       reset, start, hold;
  logic [7:0] k_len, wgt_base, act_base;
  logic       busy, done, wgt_rd_en, act_rd_en, pe_enable, clear_acc, load_weight;
  logic [7:0] wgt_rd_addr, act_rd_addr;
  logic [3:0] compute_en;

  int checks = 0;
  int errors = 0;
  logic [26:0] tr [64];

  always #5 clk = ~clk;

  systolic_array_ctrl #(
    .ARRAY_DIM(4), .K_BITS(8), .ADDR_BITS(8), .MEM_LATENCY(1), .MAC_PIPE_LATENCY(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len), .wgt_base(wgt_base),
    .act_base(act_base), .hold(hold), .busy(busy), .done(done),
    .wgt_rd_en(wgt_rd_en), .wgt_rd_addr(wgt_rd_addr), .act_rd_en(act_rd_en),
    .act_rd_addr(act_rd_addr), .pe_enable(pe_enable), .clear_acc(clear_acc),
    .load_weight(load_weight), .compute_en(compute_en)
  );

  // SRAM models (1-cycle latency, stalled with the array) and north-edge weight pipe.
  logic [63:0] wmem [256];
  logic [63:0] amem [256];
  logic [63:0] wdout, adout;
  logic [63:0] bpipe [N];
  logic [15:0] a_pass  [N][N];
  logic [15:0] acc_out [N][N];

  always @(posedge clk) begin
    if (pe_enable) begin
      if (wgt_rd_en) wdout <= wmem[wgt_rd_addr];
      if (act_rd_en) adout <= amem[act_rd_addr];
      bpipe[0] <= wdout;
      for (int r = 1; r < N; r++) bpipe[r] <= bpipe[r-1];
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      logic [15:0] a_in, b_in, wreg, areg, p1, p2, acc;
      logic v1, v2;
      logic signed [31:0] prod;
      if (c == 0) begin : g_aw
        assign a_in = adout[16*r +: 16];
      end else begin : g_ai
        assign a_in = a_pass[r][c-1];
      end
      if (r == 0) begin : g_bn
        assign b_in = wdout[16*c +: 16];
      end else begin : g_bi
        assign b_in = bpipe[r-1][16*c +: 16];
      end
      assign prod = $signed(wreg) * $signed(a_in);
      assign a_pass[r][c]  = areg;
      assign acc_out[r][c] = acc;
      always @(posedge clk) begin
        if (reset) begin
          v1 <= 1'b0;
          v2 <= 1'b0;
        end else if (pe_enable) begin
          areg <= a_in;
          p1   <= prod[30:15];
          p2   <= p1;
          v1   <= compute_en[c];
          v2   <= v1;
          if (load_weight) wreg <= b_in;
          if (clear_acc) acc <= 16'h0000;
          else if (v2) acc <= acc + p2;
        end
      end
    end
  end

  function automatic logic [26:0] snap();
    return {pe_enable, busy, done, clear_acc, load_weight, wgt_rd_en, wgt_rd_addr,
            act_rd_en, act_rd_addr, compute_en};
  endfunction

  // Expected outputs for cycle j of an unstalled job started at cycle 0 (N=4, latency 1).
  function automatic logic [26:0] job_exp(input int j, input int k, input logic [7:0] wb,
                                          input logic [7:0] ab);
    int dn;
    logic wen, aen;
    logic [7:0] wa, aa;
    logic [3:0] ce;
    dn  = (k == 0) ? 7 : 13 + k;
    wen = (j >= 2) && (j <= 5);
    wa  = wen ? wb + 8'(5 - j) : 8'h00;
    aen = (j >= 7) && (j < 7 + k);
    aa  = aen ? ab + 8'(j - 7) : 8'h00;
    for (int c = 0; c < 4; c++) ce[c] = (j >= 8 + c) && (j < 8 + c + k);
    return {1'b1, (j >= 1) && (j <= dn), j == dn, j == 1, j == 6, wen, wa, aen, aa, ce};
  endfunction

  // Starts a job at cycle 0 and records outputs each cycle at the falling edge.
  task automatic run_trace(input int ncyc, input int hlo, input int hhi, input int s2,
                           input int rc);
    for (int i = 0; i < ncyc; i++) begin
      start = (i == 0) || (i == s2);
      if (i == s2) begin
        wgt_base = 8'h80;
        k_len    = 8'd5;
      end
      hold  = (i >= hlo) && (i <= hhi);
      reset = (i == rc);
      @(negedge clk);
      tr[i] = snap();
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    hold  = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [26:0] got;
    reset = 1'b1; start = 1'b0; hold = 1'b0;
    k_len = 8'd0; wgt_base = 8'h00; act_base = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    got = snap();
    checks++;
    if (got !== IDLE_VEC) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", got, IDLE_VEC);
    end
    hold = 1'b1;
    #1;
    checks++;
    if (pe_enable !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold_pe_enable: got %b expected 0", pe_enable);
    end
    hold = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_basic_job();
    logic [26:0] e;
    k_len = 8'd3; wgt_base = 8'h10; act_base = 8'h40;
    run_trace(20, -1, -1, -1, -1);
    for (int i = 0; i < 20; i++) begin
      e = job_exp(i, 3, 8'h10, 8'h40);
      checks++;
      if (tr[i] !== e) begin
        errors++;
        $display("FAIL basic_job cycle %0d: got %h expected %h", i, tr[i], e);
      end
    end
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        checks++;
        if (acc_out[r][c] !== ((r == c) ? 16'h3000 : 16'h0000)) begin
          errors++;
          $display("FAIL basic_acc[%0d][%0d]: got %h expected %h", r, c, acc_out[r][c],
                   (r == c) ? 16'h3000 : 16'h0000);
        end
      end
    end
  endtask

  task automatic test_k_zero();
    logic [26:0] e;
    k_len = 8'd0; wgt_base = 8'h10; act_base = 8'h40;
    run_trace(10, -1, -1, -1, -1);
    for (int i = 0; i < 10; i++) begin
      e = job_exp(i, 0, 8'h10, 8'h40);
      checks++;
      if (tr[i] !== e) begin
        errors++;
        $display("FAIL k_zero cycle %0d: got %h expected %h", i, tr[i], e);
      end
    end
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        checks++;
        if (acc_out[r][c] !== 16'h0000) begin
          errors++;
          $display("FAIL k_zero_acc[%0d][%0d]: got %h expected 0000", r, c, acc_out[r][c]);
        end
      end
    end
  endtask

  task automatic test_hold_stall();
    logic [26:0] e, m;
    k_len = 8'd3; wgt_base = 8'h10; act_base = 8'h40;
    run_trace(23, 8, 10, -1, -1);
    for (int i = 0; i < 23; i++) begin
      m = '1;
      if (i < 8) begin
        e = job_exp(i, 3, 8'h10, 8'h40);
      end else if (i <= 10) begin
        e = job_exp(8, 3, 8'h10, 8'h40);
        e[26]    = 1'b0;
        e[24:21] = 4'b0000;
        e[12]    = 1'b0;
        m        = ~ADDR_FIELDS;
      end else begin
        e = job_exp(i - 3, 3, 8'h10, 8'h40);
      end
      checks++;
      if ((tr[i] & m) !== (e & m)) begin
        errors++;
        $display("FAIL hold_stall cycle %0d: got %h expected %h", i, tr[i] & m, e & m);
      end
    end
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        checks++;
        if (acc_out[r][c] !== ((r == c) ? 16'h3000 : 16'h0000)) begin
          errors++;
          $display("FAIL hold_acc[%0d][%0d]: got %h expected %h", r, c, acc_out[r][c],
                   (r == c) ? 16'h3000 : 16'h0000);
        end
      end
    end
  endtask

  task automatic test_wrap_and_restart_ignored();
    logic [26:0] e;
    k_len = 8'd3; wgt_base = 8'hFE; act_base = 8'h40;
    run_trace(20, -1, -1, 3, -1);
    for (int i = 0; i < 20; i++) begin
      e = job_exp(i, 3, 8'hFE, 8'h40);
      checks++;
      if (tr[i] !== e) begin
        errors++;
        $display("FAIL wrap_restart cycle %0d: got %h expected %h", i, tr[i], e);
      end
    end
  endtask

  task automatic test_reset_mid_job();
    logic [26:0] e;
    k_len = 8'd3; wgt_base = 8'h10; act_base = 8'h40;
    run_trace(20, -1, -1, -1, 9);
    for (int i = 0; i < 20; i++) begin
      e = (i <= 9) ? job_exp(i, 3, 8'h10, 8'h40) : IDLE_VEC;
      checks++;
      if (tr[i] !== e) begin
        errors++;
        $display("FAIL reset_mid cycle %0d: got %h expected %h", i, tr[i], e);
      end
    end
    run_trace(20, -1, -1, -1, -1);
    for (int i = 0; i < 20; i++) begin
      e = job_exp(i, 3, 8'h10, 8'h40);
      checks++;
      if (tr[i] !== e) begin
        errors++;
        $display("FAIL after_reset_job cycle %0d: got %h expected %h", i, tr[i], e);
      end
    end
    for (int r = 0; r < N; r++) begin
      checks++;
      if (acc_out[r][r] !== 16'h3000) begin
        errors++;
        $display("FAIL after_reset_acc[%0d]: got %h expected 3000", r, acc_out[r][r]);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      wmem[a] = 64'h0;
      amem[a] = 64'h0;
    end
    for (int r = 0; r < N; r++) begin
      wmem[8'h10 + r] = 64'h4000 << (16 * r);
    end
    wmem[8'hFE] = 64'h1111_2222_3333_4444;
    wmem[8'hFF] = 64'h5555_6666_7777_0123;
    wmem[8'h00] = 64'h0456_0789_0ABC_0DEF;
    wmem[8'h01] = 64'h0001_0002_0003_0004;
    for (int i = 0; i < 3; i++) amem[8'h40 + i] = 64'h2000_2000_2000_2000;

    test_reset();
    test_basic_job();
    test_k_zero();
    test_hold_stall();
    test_wrap_and_restart_ignored();
    test_reset_mid_job();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
